// File: rtl/logic_unit_arb_if.sv
// logic_unit_arb_if: two-requester operation bus plus result handshake for logic_unit_arb.
// The res_zero flag exists only when LOGIC_UNIT_ZERO_FLAG_EN is defined.
interface logic_unit_arb_if #(parameter int WIDTH = 32);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             busy;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic             res_zero;
`endif

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id, busy
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        , input res_zero
`endif
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id, busy
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        , output res_zero
`endif
    );
endinterface

// File: rtl/logic_unit_arb.sv
// logic_unit_arb: round-robin arbitrated bitwise AND/OR/XOR/XNOR unit with IDLE/EXEC/DONE FSM.
// Optional registered all-zero result flag res_zero under LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit_arb #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    logic_unit_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    state_t           nxt;
    logic             last;
    logic             gnt;
    logic             accept;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             id_r;
    logic [WIDTH-1:0] result;

    // Under contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        gnt    = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
        accept = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        result = op_r == 2'b00 ? (a_r & b_r) :
                 op_r == 2'b01 ? (a_r | b_r) :
                 op_r == 2'b10 ? (a_r ^ b_r) : ~(a_r ^ b_r);
        nxt    = state;
        if (state == IDLE && accept)
            nxt = EXEC;
        else if (state == EXEC)
            nxt = DONE;
        else if (state == DONE && bus.res_ready)
            nxt = IDLE;
    end

    assign bus.req0_ready = accept && !gnt;
    assign bus.req1_ready = accept && gnt;
    assign bus.res_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last         <= 1'b1;
            bus.res_data <= '0;
            bus.res_id   <= 1'b0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            bus.res_zero <= 1'b0;
`endif
        end else begin
            if (accept) begin
                last <= gnt;
                id_r <= gnt;
                op_r <= gnt ? bus.req1_op : bus.req0_op;
                a_r  <= gnt ? bus.req1_a : bus.req0_a;
                b_r  <= gnt ? bus.req1_b : bus.req0_b;
            end
            if (state == EXEC) begin
                bus.res_data <= result;
                bus.res_id   <= id_r;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
                bus.res_zero <= (result == '0);
`endif
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_arb.sv
// tb_logic_unit_arb: directed self-checking bench for logic_unit_arb (LOGIC_UNIT_ZERO_FLAG_EN optional).
module tb_logic_unit_arb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    logic_unit_arb_if #(.WIDTH(32)) bus ();

    logic_unit_arb #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        chk("granted_ready", id ? bus.req1_ready : bus.req0_ready, 1);
        chk("other_ready", id ? bus.req0_ready : bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("exec_busy", bus.busy, 1);
        chk("exec_res_valid", bus.res_valid, 0);
        @(negedge clk);
        #1;
        chk("done_res_valid", bus.res_valid, 1);
        chk("res_data", bus.res_data, exp);
        chk("res_id", bus.res_id, id);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        chk("res_zero", bus.res_zero, exp == 32'h0);
`endif
        @(negedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        chk("rst_res_zero", bus.res_zero, 0);
`endif

        // Continuous contention straight out of reset: grants alternate 0,1,0,1.
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'hF0F0F0F0; bus.req0_b = 32'hFF00FF00;
        bus.req1_valid = 1'b1; bus.req1_a = 32'hF0F0F0F0; bus.req1_b = 32'hFF00FF00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", bus.req0_ready, k % 2 == 0);
            chk("rr_ready1", bus.req1_ready, k % 2 == 1);
            @(negedge clk);
            #1;
            chk("rr_exec_no_ready", bus.req0_ready | bus.req1_ready, 0);
            @(negedge clk);
            #1;
            chk("rr_done_no_ready", bus.req0_ready | bus.req1_ready, 0);
            chk("rr_res_id", bus.res_id, k % 2 == 1);
            chk("rr_res_data", bus.res_data, 32'hF000F000);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;

        issue(1'b0, 2'b11, 32'hCA981547, 32'h3567EAB8, 32'h00000000);
        issue(1'b1, 2'b11, 32'h3567EAB8, 32'h3567EAB8, 32'hFFFFFFFF);
        issue(1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        issue(1'b1, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
        issue(1'b0, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);

        // Backpressure: result held for 5 cycles while both requesters knock.
        bus.res_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_a = 32'hF0F0F0F0; bus.req0_b = 32'hFF00FF00;
        @(negedge clk);
        bus.req0_op = 2'b01; bus.req0_a = 32'h12345678; bus.req0_b = 32'h0;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 32'hFFFFFFFF; bus.req1_b = 32'hFFFFFFFF;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_res_valid", bus.res_valid, 1);
            chk("hold_res_data", bus.res_data, 32'h0FF00FF0);
            chk("hold_res_id", bus.res_id, 0);
            chk("hold_no_ready", bus.req0_ready | bus.req1_ready, 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("release_res_valid", bus.res_valid, 1);
        @(negedge clk);
        #1;
        chk("release_busy", bus.busy, 0);
        chk("release_res_data", bus.res_data, 32'h0FF00FF0);
        chk("release_ready1", bus.req1_ready, 1);
        chk("release_ready0", bus.req0_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("no_accept_busy", bus.busy, 0);

        // Reset while req0's op is in EXEC: discarded, pointer back to 1.
        bus.req0_valid = 1'b1; bus.req0_op = 2'b11; bus.req0_a = 32'h0; bus.req0_b = 32'h0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("abort_exec_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_res_data", bus.res_data, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("abort_no_result", bus.res_valid, 0);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("post_rst_ready0", bus.req0_ready, 1);
        chk("post_rst_ready1", bus.req1_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
